// File: rtl/ad9122_cfg_pkg.sv
// Shared constants for the AD9122 power-up configuration sequencer.
// Optional read-back verify is built with AD9122_CFG_VERIFY_EN.
package ad9122_cfg_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_FETCH_WT = 4'd2;
  localparam logic [3:0] S_WR_REQ   = 4'd3;
  localparam logic [3:0] S_WR_WAIT  = 4'd4;
  localparam logic [3:0] S_RD_REQ   = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_NEXT     = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_ERROR    = 4'd9;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;

  localparam logic [15:0] SENTINEL = 16'hFFFF;
  localparam int          RW_BIT   = 7;

endpackage

// File: rtl/ad9122_cfg_timeout.sv
// Loadable down-counter guarding every SPI wait state.
// expired_o is high once the loaded budget has fully elapsed.
module ad9122_cfg_timeout #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD_V = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = LOAD_V;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ad9122_cfg_seq.sv
// AD9122 power-up sequencer: walks a ROM table, one SPI write per entry.
// Define AD9122_CFG_VERIFY_EN to read back and retry each write.
module ad9122_cfg_seq
  import ad9122_cfg_pkg::*;
#(
  parameter int TBL_AW      = 6,
  parameter int NUM_ENTRIES = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [TBL_AW-1:0] err_idx,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic [7:0]        spi_addr,
  output logic [7:0]        spi_wdata,
  output logic              spi_write_req,
  output logic              spi_read_req,
  input  logic [7:0]        spi_rdata,
  input  logic              spi_end
);

  localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(NUM_ENTRIES - 1);

  logic [3:0]        state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [14:0]       entry_q, entry_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic [TBL_AW-1:0] eidx_q, eidx_d;
  logic              tmr_exp;

`ifdef AD9122_CFG_VERIFY_EN
  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTW-1:0] MAX_R = RTW'(MAX_RETRY);
  logic [RTW-1:0] retry_q, retry_d;
`else
  logic unused_rd;
  assign unused_rd = ^{spi_rdata, 32'(MAX_RETRY)};
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
`ifdef AD9122_CFG_VERIFY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = ERR_NONE;
          idx_d   = '0;
          busy_d  = 1'b1;
`ifdef AD9122_CFG_VERIFY_EN
          retry_d = '0;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_FETCH_WT;
      S_FETCH_WT: begin
        entry_d = tbl_data[14:0];
        if (tbl_data == SENTINEL) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          addr_d  = {1'b0, tbl_data[14:8]};
          wdata_d = tbl_data[7:0];
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (spi_end) begin
`ifdef AD9122_CFG_VERIFY_EN
          addr_d         = {1'b0, entry_q[14:8]};
          addr_d[RW_BIT] = 1'b1;
          state_d        = S_RD_REQ;
`else
          state_d = S_NEXT;
`endif
        end else if (tmr_exp) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          code_d  = ERR_TIMEOUT;
          eidx_d  = idx_q;
          state_d = S_ERROR;
        end
      end
`ifdef AD9122_CFG_VERIFY_EN
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (spi_end) begin
          if (spi_rdata == entry_q[7:0]) begin
            state_d = S_NEXT;
          end else if (retry_q < MAX_R) begin
            retry_d = retry_q + 1'b1;
            addr_d  = {1'b0, entry_q[14:8]};
            state_d = S_WR_REQ;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            code_d  = ERR_VERIFY;
            eidx_d  = idx_q;
            state_d = S_ERROR;
          end
        end else if (tmr_exp) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          code_d  = ERR_TIMEOUT;
          eidx_d  = idx_q;
          state_d = S_ERROR;
        end
      end
`endif
      S_NEXT: begin
`ifdef AD9122_CFG_VERIFY_EN
        retry_d = '0;
`endif
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      entry_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      eidx_q  <= '0;
`ifdef AD9122_CFG_VERIFY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
`ifdef AD9122_CFG_VERIFY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Budget reloads on every request, so each wait gets the full window.
  ad9122_cfg_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == S_IDLE),
    .load_i    (state_q == S_WR_REQ || state_q == S_RD_REQ),
    .en_i      (state_q == S_WR_WAIT || state_q == S_RD_WAIT),
    .expired_o (tmr_exp)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = code_q;
  assign err_idx       = eidx_q;
  assign tbl_addr      = idx_q;
  assign spi_addr      = addr_q;
  assign spi_wdata     = wdata_q;
  assign spi_write_req = (state_q == S_WR_REQ);
`ifdef AD9122_CFG_VERIFY_EN
  assign spi_read_req  = (state_q == S_RD_REQ);
`else
  assign spi_read_req  = 1'b0;
`endif

endmodule

// File: tb/tb_ad9122_cfg_seq.sv
// Directed bench for ad9122_cfg_seq with ROM and SPI slave models.
// Verify-path vectors run only when AD9122_CFG_VERIFY_EN is defined.
module tb_ad9122_cfg_seq;

  localparam int AW = 6;
`ifdef AD9122_CFG_VERIFY_EN
  localparam int PER = 7;
`else
  localparam int PER = 5;
`endif
  localparam int LAT_DONE = 3 * PER + 1;
  localparam int LAT_TO   = 2 * PER + 3 + 64 + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_idx, tbl_addr;
  logic [15:0]   tbl_data = '0;
  logic [7:0]    spi_addr, spi_wdata;
  logic          spi_write_req, spi_read_req;
  logic [7:0]    spi_rdata = '0;
  logic          spi_end = 1'b0;

  logic [15:0] rom [64];
  logic [7:0]  smem [128];
  logic [15:0] wr_log [$];
  logic        hang_en = 1'b0;
  logic        bad_en = 1'b0;
  logic [6:0]  hang_addr = 7'h10;
  logic [6:0]  bad_addr = 7'h0A;
  int          wide_cnt = 0, both_cnt = 0, done_rise = 0;
  logic        wr_prev = 1'b0, done_prev = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  ad9122_cfg_seq #(
    .TBL_AW      (AW),
    .NUM_ENTRIES (3),
    .TIMEOUT_CYC (64),
    .MAX_RETRY   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .err_idx       (err_idx),
    .tbl_addr      (tbl_addr),
    .tbl_data      (tbl_data),
    .spi_addr      (spi_addr),
    .spi_wdata     (spi_wdata),
    .spi_write_req (spi_write_req),
    .spi_read_req  (spi_read_req),
    .spi_rdata     (spi_rdata),
    .spi_end       (spi_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Ideal slave: spi_end one cycle after a request unless told to hang.
  always @(posedge clk) begin
    spi_end <= 1'b0;
    if (!rst && spi_write_req) begin
      wr_log.push_back({spi_addr, spi_wdata});
      smem[spi_addr[6:0]] <= spi_wdata;
      if (!(hang_en && spi_addr[6:0] == hang_addr)) spi_end <= 1'b1;
    end
    if (!rst && spi_read_req) begin
      spi_rdata <= (bad_en && spi_addr[6:0] == bad_addr) ? 8'h00
                                                          : smem[spi_addr[6:0]];
      spi_end <= 1'b1;
    end
  end

  always @(posedge clk) begin
    wr_prev   <= spi_write_req;
    done_prev <= done;
    if (spi_write_req && wr_prev) wide_cnt <= wide_cnt + 1;
    if (spi_write_req && spi_read_req) both_cnt <= both_cnt + 1;
    if (done && !done_prev) done_rise <= done_rise + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fin(input int max, output int k);
    k = 1;
    while (!(done || error) && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!(done || error)) chk("wait_bound", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {busy, done, error, err_code}, 0);
    chk({tag, "_idx"}, {err_idx, tbl_addr}, 0);
    chk({tag, "_spi"}, {spi_addr, spi_wdata, spi_write_req, spi_read_req}, 0);
  endtask

  initial begin
    int k, b, r0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0] = 16'h05A5;
    rom[1] = 16'h0A3C;
    rom[2] = 16'h10FF;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Three-entry table
    b = wr_log.size();
    do_start();
    chk("t1_busy", busy, 1);
    wait_fin(400, k);
    chk("t1_latency", k, LAT_DONE);
    chk("t1_done_err", {done, error, busy}, 3'b100);
    chk("t1_nwr", wr_log.size() - b, 3);
    chk("t1_wr0", wr_log[b], 16'h05A5);
    chk("t1_wr1", wr_log[b+1], 16'h0A3C);
    chk("t1_wr2", wr_log[b+2], 16'h10FF);
    repeat (3) @(negedge clk);
    chk("t1_done_hold", done, 1);
    chk("t1_mem", {smem[5], smem[10], smem[16]}, 24'hA53CFF);

    // start while busy and start coincident with DONE
    b  = wr_log.size();
    r0 = done_rise;
    do_start();
    for (int i = 2; i <= LAT_DONE; i++) begin
      @(negedge clk);
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      if (i == LAT_DONE) begin
        chk("t2_done_state", {done, busy}, 2'b10);
        start = 1'b1;
      end
    end
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_idle", {done, busy, error}, 3'b100);
    chk("t2_nwr", wr_log.size() - b, 3);
    chk("t2_done_once", done_rise - r0, 1);

    // Sentinel at index 1
    rom[1] = 16'hFFFF;
    b = wr_log.size();
    do_start();
    wait_fin(400, k);
    repeat (4) @(negedge clk);
    chk("t3_done_err", {done, error, busy}, 3'b100);
    chk("t3_nwr", wr_log.size() - b, 1);
    chk("t3_wr0", wr_log[b], 16'h05A5);
    rom[1] = 16'h0A3C;

    // Slave hangs on entry 2
    hang_en = 1'b1;
    b = wr_log.size();
    do_start();
    wait_fin(400, k);
    chk("t4_latency", k, LAT_TO);
    chk("t4_flags", {done, error, busy}, 3'b010);
    chk("t4_code", err_code, 2'b01);
    chk("t4_idx", err_idx, 2);
    chk("t4_nwr", wr_log.size() - b, 3);
    @(negedge clk);

    // Reset while stuck in WR_WAIT, then restart
    b = wr_log.size();
    do_start();
    repeat (20) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("t5_rst");
    hang_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_nwr_abort", wr_log.size() - b, 3);
    b = wr_log.size();
    do_start();
    wait_fin(400, k);
    chk("t5_done_err", {done, error}, 2'b10);
    chk("t5_nwr", wr_log.size() - b, 3);
    chk("t5_first", wr_log[b], 16'h05A5);

`ifdef AD9122_CFG_VERIFY_EN
    // Read-back of 0x0A returns 0: one write plus two retries, then error
    @(negedge clk);
    bad_en = 1'b1;
    b = wr_log.size();
    do_start();
    wait_fin(400, k);
    chk("v_flags", {done, error}, 2'b01);
    chk("v_code", err_code, 2'b10);
    chk("v_idx", err_idx, 1);
    chk("v_nwr", wr_log.size() - b, 4);
    chk("v_wr1", wr_log[b+1], 16'h0A3C);
    chk("v_wr3", wr_log[b+3], 16'h0A3C);
    bad_en = 1'b0;
`endif

    chk("req_width", wide_cnt, 0);
    chk("req_both", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
